seg7_scan_driver: RTL

Time-multiplexed seven-segment display driver for the i281 PONG build. It sits directly downstream of the data memory and consumes the eight 8-bit `Seven_Seg0`–`Seven_Seg7` segment patterns that memory exposes. It drives a shared 8-bit segment bus plus eight digit enables, with anti-ghosting blanking between digits. All eight patterns are snapshotted once per frame so that a CPU write mid-frame never tears the display.

---
 rtl/seg7_scan_driver_if.sv | 34 +++
 rtl/seg7_scan_driver.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver_if.sv
// Bundle between the data memory / scan consumer and the seven-segment
// scan driver: run enable, the eight raw digit patterns, and the
// multiplexed display outputs.
interface seg7_scan_driver_if;
    logic       Enable;
    logic [7:0] Seven_Seg0;
    logic [7:0] Seven_Seg1;
    logic [7:0] Seven_Seg2;
    logic [7:0] Seven_Seg3;
    logic [7:0] Seven_Seg4;
    logic [7:0] Seven_Seg5;
    logic [7:0] Seven_Seg6;
    logic [7:0] Seven_Seg7;
    logic [7:0] SEG_OUT;
    logic [7:0] DIGIT_EN;
    logic [2:0] Digit_Index;
    logic       Frame_Start;

    // Pattern source side (memory / testbench)
    modport master (
        output Enable,
        output Seven_Seg0, Seven_Seg1, Seven_Seg2, Seven_Seg3,
        output Seven_Seg4, Seven_Seg5, Seven_Seg6, Seven_Seg7,
        input  SEG_OUT, DIGIT_EN, Digit_Index, Frame_Start
    );

    // Scan driver side
    modport slave (
        input  Enable,
        input  Seven_Seg0, Seven_Seg1, Seven_Seg2, Seven_Seg3,
        input  Seven_Seg4, Seven_Seg5, Seven_Seg6, Seven_Seg7,
        output SEG_OUT, DIGIT_EN, Digit_Index, Frame_Start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver. Each digit slot lasts TICK_DIV
// clocks, the first BLANK_CYCLES of which are dark to suppress ghosting.
// All eight patterns are captured into shadow registers at the start of each
// frame so mid-frame CPU writes never tear the display. Outputs are fully
// registered and computed from the next-state values so they line up with
// the state registers.
module seg7_scan_driver #(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    seg7_scan_driver_if.slave bus
);

    localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    // XOR mask that turns active-high encodings into board polarity
    localparam logic [7:0]      POL     = ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             snap_d;

    logic [7:0]       pattern  [8];
    logic [7:0]       shadow_q [8];
    logic [7:0]       show_pat;

    logic [7:0]       seg_q, seg_d;
    logic [7:0]       en_q, en_d;
    logic             frame_q;

    assign pattern[0] = bus.Seven_Seg0;
    assign pattern[1] = bus.Seven_Seg1;
    assign pattern[2] = bus.Seven_Seg2;
    assign pattern[3] = bus.Seven_Seg3;
    assign pattern[4] = bus.Seven_Seg4;
    assign pattern[5] = bus.Seven_Seg5;
    assign pattern[6] = bus.Seven_Seg6;
    assign pattern[7] = bus.Seven_Seg7;

    // Phase within a slot: the leading BLANK_CYCLES counts are dark.
    // Done in signed int so BLANK_CYCLES = 0 does not become a constant
    // unsigned comparison.
    function automatic state_t phase_of(input logic [CNT_W-1:0] c);
        return (int'(c) < BLANK_CYCLES) ? BLANK : SHOW;
    endfunction

    // Scanner state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: slot counting, digit advance and frame snapshot request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (bus.Enable) begin
                    snap_d  = 1'b1;
                    state_d = phase_of('0);
                end
            end
            default: begin
                if (!bus.Enable) begin
                    // Drop wins over a coincident wrap: no snapshot
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    snap_d  = (idx_q == 3'd7);
                    state_d = phase_of('0);
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = phase_of(cnt_q + 1'b1);
                end
            end
        endcase
    end

    // Pattern for the upcoming cycle; on a snapshot cycle the shadow is not
    // yet loaded, so take the live input directly.
    always_comb begin
        show_pat = snap_d ? pattern[idx_d] : shadow_q[idx_d];
        seg_d    = POL;
        en_d     = POL;
        if (state_d == SHOW) begin
            seg_d = show_pat ^ POL;
            en_d  = (8'h01 << idx_d) ^ POL;
        end
    end

    // Registered display outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            seg_q   <= POL;
            en_q    <= POL;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            en_q    <= en_d;
            frame_q <= snap_d;
        end
    end

    // Per-digit shadow registers, reloaded once per frame
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_shadow
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    shadow_q[gi] <= '0;
                end else if (snap_d) begin
                    shadow_q[gi] <= pattern[gi];
                end
            end
        end
    endgenerate

    assign bus.SEG_OUT     = seg_q;
    assign bus.DIGIT_EN    = en_q;
    assign bus.Digit_Index = idx_q;
    assign bus.Frame_Start = frame_q;

endmodule
